// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder.
//   DEF_WIDTH  : default operand/sum width
//   DEF_STAGES : default pipeline depth
//   seg_width  : per-stage segment width, guarded against a zero stage count
package adder_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STAGES = 2;

  function automatic int unsigned seg_width(int unsigned width, int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
//   in_valid/in_ready  : operand beat handshake (a, b, sub)
//   out_valid/out_ready: result beat handshake (sum, carry, overflow)
//   master: the block feeding operands and taking results; slave: the adder.
interface adder_pipe_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/adder_seg.sv
// Combinational ripple-carry adder for one pipeline segment.
//   a, b : segment operands
//   cin  : carry in
//   s    : segment sum
//   cout : carry out of the segment MSB
module adder_seg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with valid/ready handshake on both sides.
//   clk : clock, rising edge
//   rst : synchronous active-high reset; drops all in-flight beats
//   bus : adder_pipe_if slave (in_valid/in_ready/a/b/sub in,
//         out_valid/out_ready/sum/carry/overflow out)
// Stage k adds operand segment k plus the carry registered by stage k-1; operands
// and partial sum travel with the beat. A stalled output freezes every stage.
// Optional macro ADDER_PIPE_SAT_EN: unsigned saturation of sum at the output.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input logic         clk,
  input logic         rst,
  adder_pipe_if.slave bus
);
  localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
  localparam int unsigned LAST = (STAGES == 0) ? 0 : STAGES - 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_check
    $error("adder_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // Per-stage registers; b is kept pre-inverted for subtraction.
  logic [STAGES-1:0][WIDTH-1:0] a_q, bp_q, s_q;
  logic [STAGES-1:0]            v_q, c_q, sub_q;

  // Inputs seen by each stage: the external beat for stage 0, else the previous stage.
  logic [STAGES-1:0][WIDTH-1:0] in_a, in_bp, in_s, nxt_s;
  logic [STAGES-1:0]            in_v, in_c, in_sub;
  logic [STAGES-1:0][SEG-1:0]   seg_s;
  logic [STAGES-1:0]            seg_c;
  logic                         advance;

  assign advance      = !(v_q[LAST] && !bus.out_ready);
  assign bus.in_ready = advance;

  always_comb begin
    in_a   = '0;
    in_bp  = '0;
    in_s   = '0;
    in_v   = '0;
    in_c   = '0;
    in_sub = '0;
    in_a[0]   = bus.a;
    in_bp[0]  = bus.sub ? ~bus.b : bus.b;
    in_c[0]   = bus.sub;  // a + ~b + 1 for subtraction
    in_sub[0] = bus.sub;
    in_v[0]   = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      in_a[k]   = a_q[k-1];
      in_bp[k]  = bp_q[k-1];
      in_s[k]   = s_q[k-1];
      in_c[k]   = c_q[k-1];
      in_sub[k] = sub_q[k-1];
      in_v[k]   = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_seg #(
      .WIDTH(SEG)
    ) u_seg (
      .a   (in_a[k][k*SEG +: SEG]),
      .b   (in_bp[k][k*SEG +: SEG]),
      .cin (in_c[k]),
      .s   (seg_s[k]),
      .cout(seg_c[k])
    );
  end

  always_comb begin
    nxt_s = in_s;
    for (int k = 0; k < STAGES; k++) begin
      nxt_s[k][k*SEG +: SEG] = seg_s[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      a_q   <= '0;
      bp_q  <= '0;
      s_q   <= '0;
      c_q   <= '0;
      sub_q <= '0;
    end else if (advance) begin
      v_q   <= in_v;
      a_q   <= in_a;
      bp_q  <= in_bp;
      s_q   <= nxt_s;
      c_q   <= seg_c;
      sub_q <= in_sub;
    end
  end

  logic [WIDTH-1:0] raw_sum;
  assign raw_sum       = s_q[LAST];
  assign bus.out_valid = v_q[LAST];
  assign bus.carry     = c_q[LAST];
  assign bus.overflow  = (a_q[LAST][WIDTH-1] == bp_q[LAST][WIDTH-1]) &&
                         (raw_sum[WIDTH-1] != a_q[LAST][WIDTH-1]);

  always_comb begin
    bus.sum = raw_sum;
`ifdef ADDER_PIPE_SAT_EN
    // Flags keep reporting the raw result; only the sum clamps.
    if (!sub_q[LAST] && c_q[LAST]) begin
      bus.sum = '1;
    end else if (sub_q[LAST] && !c_q[LAST]) begin
      bus.sum = '0;
    end
`endif
  end

  // Only MSBs of the final-stage operands and (in the default build) none of sub_q are read.
  logic unused_bits;
  assign unused_bits = ^{a_q, bp_q, sub_q};
endmodule

// File: tb/tb_adder_pipe.sv
module tb_adder_pipe;
`ifdef ADDER_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(8)) bus ();

  adder_pipe #(
    .WIDTH (8),
    .STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_emit = 0;
  res_t q[$];
  bit   stall_prev = 1'b0;
  res_t held;

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(logic [7:0] a, logic [7:0] b, logic sub);
    int   ua, ub, sa, sb, r, sr;
    res_t o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r       = ua - ub;
      sr      = sa - sb;
      o.carry = (ua >= ub);
    end else begin
      r       = ua + ub;
      sr      = sa + sb;
      o.carry = (r > 255);
    end
    o.sum = r[7:0];
    o.ovf = (sr > 127) || (sr < -128);
    if (SAT) begin
      if (!sub && o.carry) o.sum = 8'hFF;
      if (sub && !o.carry) o.sum = 8'h00;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: evaluate handshakes of the current cycle, then move to the next negedge.
  task automatic tick(output bit acc);
    res_t e;
    #1;
    acc = 1'b0;
    check("in_ready_rule", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
    if (stall_prev) begin
      check("hold_sum", 32'(bus.sum), 32'(held.sum));
      check("hold_carry", 32'(bus.carry), 32'(held.carry));
      check("hold_ovf", 32'(bus.overflow), 32'(held.ovf));
    end
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        n_emit++;
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got sum 0x%0h with no beat outstanding", bus.sum);
        end else begin
          e = q.pop_front();
          check("sb_sum", 32'(bus.sum), 32'(e.sum));
          check("sb_carry", 32'(bus.carry), 32'(e.carry));
          check("sb_ovf", 32'(bus.overflow), 32'(e.ovf));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.sub));
        acc = 1'b1;
      end
    end
    stall_prev = !rst && bus.out_valid && !bus.out_ready;
    held.sum   = bus.sum;
    held.carry = bus.carry;
    held.ovf   = bus.overflow;
    @(negedge clk);
  endtask

  vec_t       tbl[8];
  logic [7:0] ba[4];
  logic [7:0] bb[4];
  bit         acc;
  int         lat;
  int         idx;
  int         emit0;

  initial begin
    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, SAT ? 8'hFF : 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h05, 8'h07, 1'b1, SAT ? 8'h00 : 8'hFE, 1'b0, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h80, 8'h80, 1'b0, SAT ? 8'hFF : 8'h00, 1'b1, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    tick(acc);
    tick(acc);
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_sum", 32'(bus.sum), 32'(0));
    check("rst_carry", 32'(bus.carry), 32'(0));
    check("rst_ovf", 32'(bus.overflow), 32'(0));
    rst = 1'b0;

    // Directed vectors, one beat at a time.
    foreach (tbl[i]) begin
      bus.a        = tbl[i].a;
      bus.b        = tbl[i].b;
      bus.sub      = tbl[i].sub;
      bus.in_valid = 1'b1;
      tick(acc);
      check("vec_accept", 32'(acc), 32'(1));
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
        tick(acc);
        lat++;
      end
      check("vec_latency", 32'(lat), 32'(2));
      check("vec_sum", 32'(bus.sum), 32'(tbl[i].sum));
      check("vec_carry", 32'(bus.carry), 32'(tbl[i].carry));
      check("vec_ovf", 32'(bus.overflow), 32'(tbl[i].ovf));
      tick(acc);
    end

    // Four back-to-back beats, output held off for the first five cycles.
    ba = '{8'h11, 8'hF0, 8'h7E, 8'h81};
    bb = '{8'h22, 8'h20, 8'h03, 8'h02};
    idx   = 0;
    emit0 = n_emit;
    for (int t = 0; t < 40; t++) begin
      if (idx >= 4 && q.size() == 0 && t >= 6) break;
      bus.in_valid  = (idx < 4);
      bus.a         = ba[idx % 4];
      bus.b         = bb[idx % 4];
      bus.sub       = idx[0];
      bus.out_ready = (t >= 5);
      tick(acc);
      if (acc) idx++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("b2b_emitted", 32'(n_emit - emit0), 32'(4));
    check("b2b_queue_empty", 32'(q.size()), 32'(0));

    // Reset with two beats in flight and a third offered during reset.
    bus.out_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 10 && idx < 2; t++) begin
      bus.in_valid = 1'b1;
      bus.a        = 8'h40 + 8'(idx);
      bus.b        = 8'h01;
      bus.sub      = 1'b0;
      tick(acc);
      if (acc) idx++;
    end
    check("rst_beats_in", 32'(idx), 32'(2));
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    tick(acc);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    stall_prev = 1'b0;
    check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    check("midrst_in_ready", 32'(bus.in_ready), 32'(1));
    bus.out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick(acc);
      check("midrst_quiet", 32'(bus.out_valid), 32'(0));
    end

    // in_valid while rst is high on an idle pipe must not load a beat.
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    tick(acc);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick(acc);
      check("rst_ignore_in", 32'(bus.out_valid), 32'(0));
    end

    // Random traffic against the reference model.
    for (int t = 0; t < 600; t++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.sub       = 1'($urandom);
      tick(acc);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && q.size() != 0; t++) begin
      tick(acc);
    end
    check("drain_empty", 32'(q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
